// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the funct3 op codes, the 2-bit FSM state encoding and small op-decode helpers.
// No logic or state lives here; everything is constants and pure functions.
package muldiv_pkg;

  // RV32M/RV64M funct3 encodings
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // All divide/remainder ops have funct3[2] set.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Purpose: final sign correction and result select for the multiply/divide unit.
// Latency: purely combinational (0 cycles).
// Backpressure: none; output follows inputs.
// Ports:
//   op      funct3 of the operation being finished
//   acc     2*XLEN accumulator: full product, or {remainder, quotient} for divides
//   negRes  negate the product / quotient (operand signs differ)
//   negRem  negate the remainder (dividend was negative)
//   result  selected XLEN-bit result
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic [2*XLEN-1:0] acc,
  input  logic              negRes,
  input  logic              negRem,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  // Product negate must span the full 2*XLEN so MULH* see the correct borrow.
  assign prod = negRes ? -acc : acc;
  assign quot = negRes ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = negRem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    case (op)
      MD_MUL:                       result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = quot;
      default:                      result = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Purpose: iterative RV32M/RV64M multiply/divide unit beside the EX-stage ALU.
// Latency: XLEN+2 cycles acceptance-to-resp_valid iterative; 1 cycle for div special cases / MUL_FAST multiply.
// Backpressure: req_ready only in IDLE; busy while any op is in flight; result held until overwritten.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid / req_ready  request handshake (accepted when both high and flush low)
//   op, a, b               funct3 and rs1/rs2 values, captured at acceptance
//   flush                  abort an op in CALC/FINAL; blocks acceptance in IDLE
//   busy, resp_valid       stall indication and one-cycle result strobe
//   result                 last written result
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit MUL_FAST = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   magOp;    // multiplicand for multiplies, divisor for divides
  logic [2:0]        opReg;
  logic              negRes;
  logic              negRem;

  // ---------------- request decode (valid only while IDLE) ----------------
  logic            accept;
  logic            sgnA, sgnB;
  logic [XLEN-1:0] magAIn, magBIn;
  logic            divByZero, overflow, special, fastMul;
  logic [XLEN-1:0] specResult;

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);
  assign accept     = req_valid && req_ready && !flush;

  assign sgnA   = is_signed_a(op) && a[XLEN-1];
  assign sgnB   = is_signed_b(op) && b[XLEN-1];
  // Magnitude of the most-negative value is 2^(XLEN-1), which fits unsigned.
  assign magAIn = sgnA ? -a : a;
  assign magBIn = sgnB ? -b : b;

  assign divByZero = (b == '0);
  assign overflow  = ((op == MD_DIV) || (op == MD_REM)) && (a == MOST_NEG) && (b == '1);
  assign special   = is_div(op) && (divByZero || overflow);
  assign fastMul   = MUL_FAST && !is_div(op);

  // op[1] distinguishes REM/REMU from DIV/DIVU.
  always_comb begin
    specResult = '0;
    if (divByZero) specResult = op[1] ? a : '1;
    else           specResult = op[1] ? '0 : MOST_NEG;
  end

  // ---------------- single-cycle multiply (MUL_FAST builds only) ----------------
  logic [2*XLEN-1:0] fastProd;
  generate
    if (MUL_FAST) begin : gFast
      assign fastProd = {{XLEN{1'b0}}, magAIn} * {{XLEN{1'b0}}, magBIn};
    end else begin : gNoFast
      assign fastProd = '0;
    end
  endgenerate

  // ---------------- iteration step ----------------
  // Multiply: right-shifting shift-add; acc low half starts as the multiplier.
  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] mulStep;
  assign mulSum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, magOp};
  assign mulStep = acc[0] ? {mulSum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

  // Divide: restoring; acc = {partial remainder, dividend bits shifting into quotient}.
  // The partial remainder stays below the divisor, so the trial difference
  // has its top bit set exactly when the subtraction must be undone.
  logic [XLEN:0]     divShift, divTrial;
  logic [2*XLEN-1:0] divStep;
  assign divShift = acc[2*XLEN-1:XLEN-1];
  assign divTrial = divShift - {1'b0, magOp};
  assign divStep  = divTrial[XLEN] ? {divShift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {divTrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  // ---------------- sign correction ----------------
  // In IDLE the fixer sees the live request (MUL_FAST path); otherwise the registered op.
  logic              idleSel;
  logic [2*XLEN-1:0] fixAcc;
  logic [2:0]        fixOp;
  logic              fixNegRes, fixNegRem;
  logic [XLEN-1:0]   fixResult;

  assign idleSel   = (state == IDLE);
  assign fixAcc    = idleSel ? fastProd : acc;
  assign fixOp     = idleSel ? op : opReg;
  assign fixNegRes = idleSel ? (sgnA ^ sgnB) : negRes;
  assign fixNegRem = idleSel ? sgnA : negRem;

  muldiv_sign_fix #(.XLEN(XLEN)) uSignFix (
    .op     (fixOp),
    .acc    (fixAcc),
    .negRes (fixNegRes),
    .negRem (fixNegRem),
    .result (fixResult)
  );

  // ---------------- FSM and datapath state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      magOp  <= '0;
      opReg  <= '0;
      negRes <= 1'b0;
      negRem <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opReg  <= op;
            negRes <= sgnA ^ sgnB;
            negRem <= sgnA;
            cnt    <= '0;
            if (special) begin
              result <= specResult;
              state  <= DONE;
            end else if (fastMul) begin
              result <= fixResult;
              state  <= DONE;
            end else begin
              magOp <= is_div(op) ? magBIn : magAIn;
              acc   <= {{XLEN{1'b0}}, (is_div(op) ? magAIn : magBIn)};
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= is_div(opReg) ? divStep : mulStep;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN - 1)) state <= FINAL;
          end
        end
        FINAL: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            result <= fixResult;
            state  <= DONE;
          end
        end
        default: state <= IDLE;   // DONE: strobe for one cycle
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: XLEN=32 iterative unit and XLEN=64 MUL_FAST unit side by side.
// Table-driven vectors with a scoreboard queue, plus hand sequences for flush/reset.
// All expected values are constants computed by hand.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [2:0]  op;
  logic        reqValid32, reqReady32, busy32, respValid32;
  logic [31:0] a32, b32, result32;
  logic        reqValid64, reqReady64, busy64, respValid64;
  logic [63:0] a64, b64, result64;

  muldiv_unit #(.XLEN(32), .MUL_FAST(1'b0)) dut32 (
    .clk(clk), .rst(rst), .req_valid(reqValid32), .req_ready(reqReady32),
    .op(op), .a(a32), .b(b32), .flush(flush), .busy(busy32),
    .resp_valid(respValid32), .result(result32)
  );

  muldiv_unit #(.XLEN(64), .MUL_FAST(1'b1)) dut64 (
    .clk(clk), .rst(rst), .req_valid(reqValid64), .req_ready(reqReady64),
    .op(op), .a(a64), .b(b64), .flush(flush), .busy(busy64),
    .resp_valid(respValid64), .result(result64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is64;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [63:0] exp;
    int          lat;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sbQ[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] lastExp32 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input bit is64, input logic [2:0] o, input logic [63:0] av,
                        input logic [63:0] bv, input logic [63:0] ex, input int lat,
                        input string nm);
    vec_t v;
    v.is64 = is64; v.op = o; v.a = av; v.b = bv; v.exp = ex; v.lat = lat; v.name = nm;
    vecs.push_back(v);
  endtask

  // Drive one request, push its expectation, then watch for the response.
  task automatic runOp(input vec_t v);
    int   n;
    int   stuck;
    bit   seen;
    sb_t  e;
    logic ready, bsy, resp;
    logic [63:0] res;
    @(negedge clk);
    check({v.name, " ready-before"}, v.is64 ? reqReady64 : reqReady32, 1);
    op = v.op; a32 = v.a[31:0]; b32 = v.b[31:0]; a64 = v.a; b64 = v.b;
    if (v.is64) reqValid64 = 1'b1; else reqValid32 = 1'b1;
    sbQ.push_back('{exp: v.exp, lat: v.lat});
    @(negedge clk);
    reqValid32 = 1'b0; reqValid64 = 1'b0;
    // Scramble inputs after acceptance; the op in flight must not notice.
    op = v.op ^ 3'b101; a32 = ~a32; b32 = b32 + 32'd3; a64 = ~a64; b64 = b64 + 64'd3;
    n = 1; seen = 1'b0; stuck = 0;
    while (!seen && n <= 200) begin
      ready = v.is64 ? reqReady64 : reqReady32;
      bsy   = v.is64 ? busy64 : busy32;
      resp  = v.is64 ? respValid64 : respValid32;
      res   = v.is64 ? result64 : {32'b0, result32};
      if (ready !== 1'b0 || bsy !== 1'b1) stuck++;
      if (resp === 1'b1) begin
        seen = 1'b1;
        e = sbQ.pop_front();
        check({v.name, " result"}, res, e.exp);
        check({v.name, " latency"}, 64'(n), 64'(e.lat));
      end else begin
        n++;
        @(negedge clk);
      end
    end
    check({v.name, " resp-seen"}, 64'(seen), 1);
    check({v.name, " busy/ready while active"}, 64'(stuck), 0);
    @(negedge clk);
    check({v.name, " idle-after"}, v.is64 ? {62'b0, reqReady64, busy64} : {62'b0, reqReady32, busy32}, 2'b10);
    if (!v.is64) lastExp32 = v.exp[31:0];
  endtask

  // Start a 32-bit DIV, then abort it in CALC cycle 10 with flush or rst.
  task automatic abortOp(input bit useRst);
    int stray;
    @(negedge clk);
    op = MD_DIV; a32 = 32'd1000; b32 = 32'd3; reqValid32 = 1'b1;
    @(negedge clk);
    reqValid32 = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    if (useRst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    check(useRst ? "rst ready" : "flush ready", reqReady32, 1);
    check(useRst ? "rst busy" : "flush busy", busy32, 0);
    check(useRst ? "rst resp" : "flush resp", respValid32, 0);
    check(useRst ? "rst result" : "flush result", result32, useRst ? 64'd0 : {32'b0, lastExp32});
    stray = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (respValid32 !== 1'b0) stray++;
    end
    check(useRst ? "rst no-resp" : "flush no-resp", 64'(stray), 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; op = '0;
    reqValid32 = 1'b0; a32 = '0; b32 = '0;
    reqValid64 = 1'b0; a64 = '0; b64 = '0;

    // 32-bit iterative unit: latency XLEN+2 = 34, special cases 1
    addVec(0, MD_MUL,    64'd7,        64'hFFFFFFFD, 64'hFFFFFFEB, 34, "MUL 7*-3");
    addVec(0, MD_MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 34, "MULHU max");
    addVec(0, MD_MULH,   64'h80000000, 64'h80000000, 64'h40000000, 34, "MULH min*min");
    addVec(0, MD_MULHSU, 64'hFFFFFFFF, 64'd2,        64'hFFFFFFFF, 34, "MULHSU -1*2");
    addVec(0, MD_MULHSU, 64'd2,        64'h80000000, 64'h00000001, 34, "MULHSU 2*2^31");
    addVec(0, MD_MULH,   64'hFFFFFFFD, 64'd5,        64'hFFFFFFFF, 34, "MULH -3*5");
    addVec(0, MD_DIV,    64'hFFFFFFF9, 64'd2,        64'hFFFFFFFD, 34, "DIV -7/2");
    addVec(0, MD_REM,    64'hFFFFFFF9, 64'd2,        64'hFFFFFFFF, 34, "REM -7/2");
    addVec(0, MD_DIV,    64'd7,        64'hFFFFFFFE, 64'hFFFFFFFD, 34, "DIV 7/-2");
    addVec(0, MD_REM,    64'd7,        64'hFFFFFFFE, 64'h00000001, 34, "REM 7/-2");
    addVec(0, MD_DIVU,   64'd100,      64'd7,        64'd14,       34, "DIVU 100/7");
    addVec(0, MD_REMU,   64'd100,      64'd7,        64'd2,        34, "REMU 100/7");
    addVec(0, MD_DIVU,   64'h80000000, 64'hFFFFFFFF, 64'd0,        34, "DIVU min/max");
    addVec(0, MD_REMU,   64'h80000000, 64'hFFFFFFFF, 64'h80000000, 34, "REMU min/max");
    addVec(0, MD_DIVU,   64'd5,        64'd0,        64'hFFFFFFFF, 1,  "DIVU 5/0");
    addVec(0, MD_REM,    64'd5,        64'd0,        64'd5,        1,  "REM 5/0");
    addVec(0, MD_DIV,    64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1,  "DIV overflow");
    addVec(0, MD_REM,    64'h80000000, 64'hFFFFFFFF, 64'd0,        1,  "REM overflow");
    // 64-bit unit with single-cycle multiply
    addVec(1, MD_MUL,    64'd3, 64'd5, 64'd15, 1, "MUL64 3*5");
    addVec(1, MD_MULHU,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 1, "MULHU64 max");
    addVec(1, MD_MULH,   64'hFFFFFFFFFFFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFF, 1, "MULH64 -1*2");
    addVec(1, MD_DIV,    64'hFFFFFFFFFFFFFF9C, 64'd7, 64'hFFFFFFFFFFFFFFF2, 66, "DIV64 -100/7");
    addVec(1, MD_REM,    64'hFFFFFFFFFFFFFF9C, 64'd7, 64'hFFFFFFFFFFFFFFFE, 66, "REM64 -100/7");

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset ready32",  reqReady32,  1);
    check("reset busy32",   busy32,      0);
    check("reset resp32",   respValid32, 0);
    check("reset result32", result32,    0);
    check("reset ready64",  reqReady64,  1);
    check("reset result64", result64,    0);

    for (int i = 0; i < vecs.size(); i++) runOp(vecs[i]);

    // Flush together with req_valid in IDLE: request must be ignored.
    @(negedge clk);
    op = MD_DIVU; a32 = 32'd5; b32 = 32'd0; reqValid32 = 1'b1; flush = 1'b1;
    @(negedge clk);
    reqValid32 = 1'b0; flush = 1'b0;
    check("flush-idle busy", busy32, 0);
    check("flush-idle resp", respValid32, 0);
    @(negedge clk);
    check("flush-idle resp later", respValid32, 0);

    // Flush during DONE: strobe still visible.
    op = MD_DIVU; a32 = 32'd9; b32 = 32'd0; reqValid32 = 1'b1;
    @(negedge clk);
    reqValid32 = 1'b0; flush = 1'b1;
    #1;
    check("flush-done resp", respValid32, 1);
    check("flush-done result", result32, 64'hFFFFFFFF);
    @(negedge clk);
    flush = 1'b0;
    check("flush-done idle", reqReady32, 1);
    lastExp32 = 32'hFFFFFFFF;

    abortOp(1'b0);
    abortOp(1'b1);

    check("scoreboard empty", 64'(sbQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit implementing the RV32M/RV64M funct3 operation set. It sits beside the ALU in the EX stage of the pipelined core. The core stalls IF/ID/EX while the unit is busy and takes the result on resp_valid. Operand width and the multiply implementation are generic, so the same block serves XLEN=32 and XLEN=64 builds.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
MUL_FAST, 0, 1 = multiply computed combinationally at acceptance (1-cycle latency); 0 = iterative shift-add.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  operation request from EX.
req_ready  out  1  unit idle and able to accept.
op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
a  in  XLEN  rs1 value (already forwarded).
b  in  XLEN  rs2 value (already forwarded).
flush  in  1  abort the in-flight op (branch/jump flush of EX).
busy  out  1  op in flight; the core ORs this into its stall.
resp_valid  out  1  one-cycle pulse: result valid.
result  out  XLEN  op result; held until the next accepted request.

Behaviour:
- Reset: state IDLE; req_ready=1, busy=0, resp_valid=0, result=0, counter=0.
- Accept condition: req_valid && req_ready && !flush. Operands and op are registered on acceptance.
- States:
  - IDLE: accepts a request. Goes to DONE for special cases or for a MUL_FAST multiply. Otherwise loads magnitudes, clears the accumulator and counter, and goes to CALC.
  - CALC: one iteration per cycle. When counter==XLEN-1, goes to FINAL.
  - FINAL: applies sign correction and writes result; goes to DONE.
  - DONE: resp_valid=1 for exactly this cycle; returns to IDLE.
- Latency from the acceptance edge to the resp_valid cycle:
  - Iterative op: XLEN+2 cycles (34 for XLEN=32).
  - Special case or MUL_FAST multiply: 1 cycle.
- req_ready=1 only in IDLE. busy = (state != IDLE). No new request is accepted in DONE; back-to-back throughput is one op per latency+1 cycles.
- Multiply:
  - Operand signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned-equivalent.
  - Datapath: magnitudes multiplied into a 2*XLEN accumulator; a 2*XLEN two's-complement negate applies if the operand signs differ.
  - Result: MUL returns bits [XLEN-1:0]; the MULH* ops return bits [2*XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes, one quotient bit per CALC cycle.
  - Quotient is negated if the signs differ (DIV only). Remainder takes the sign of the dividend (REM only).
- Special cases, resolved in IDLE with 1-cycle latency:
  - b==0: DIV/DIVU return all ones; REM/REMU return a.
  - Signed overflow, a==most-negative and b==all-ones: DIV returns most-negative; REM returns 0.
- Flush:
  - In CALC or FINAL: next state IDLE, no resp_valid, result unchanged.
  - In DONE: resp_valid is still asserted; the core discards it.
  - Flush with req_valid in IDLE: the request is ignored.
- Reset mid-operation: forces IDLE next cycle with the reset values; no resp_valid is emitted.
- Input changes on a/b/op after acceptance have no effect.
- Width rules:
  - All arithmetic is unsigned on XLEN-bit magnitudes.
  - Magnitude of most-negative equals 2^(XLEN-1), which is representable unsigned.
  - The counter does not wrap within an op; it is cleared on each acceptance.

Decomposition:
- Shared package muldiv_pkg holds:
  - op localparams (MD_MUL..MD_REMU),
  - state encoding (IDLE, CALC, FINAL, DONE; 2 bits),
  - helper functions is_div(op) and is_signed_a/b(op).
- One natural sub-module: muldiv_sign_fix, a combinational negate/select that produces the final result from accumulator, quotient, remainder and sign flags.
- FSM, counter and iteration datapath stay in muldiv_unit.

Test Plan:
- XLEN=32, MUL_FAST=0: MUL a=7, b=0xFFFFFFFD -> resp_valid 34 cycles after acceptance, result 0xFFFFFFEB; busy high throughout; req_ready low until after DONE.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF in 1 cycle. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- DIV accepted, flush asserted at cycle 10 of CALC -> no resp_valid ever; req_ready=1 the next cycle; result keeps its previous value. Repeat with rst instead of flush -> all outputs at reset values.
- XLEN=64, MUL_FAST=1: MUL 3×5 -> 15 in 1 cycle. DIV 64-bit -100/7 -> -14 (0xFFFFFFFFFFFFFFF2) after 66 cycles.
